systolic_feed_ctrl: RTL and testbench
=====================================

Name: systolic_feed_ctrl

Overview:
- Sequences one N x N matrix multiply on the PE systolic array. A is fed from the left edge (pe_a) and B from the top edge (pe_b).
- On start, it:
  - clears the PE accumulators;
  - streams column k of A and row k of B from the operand buffers for k = 0..N-1;
  - applies the diagonal skew, so lane i is delayed i cycles and idle slots carry zero;
  - waits for the array to drain, then pulses done.
- It sits between the operand buffers and the PE array top level.

Parameters:
- N, 4, array dimension and inner dimension (rows/columns of the PE grid); N >= 2.
- DW, 32, operand width (IEEE-754 single, passed through untouched).
- DRAIN_CYC, 8, cycles to wait after the last operand leaves the controller before results are final; >= 1.
- KW, $clog2(N), width of the k index.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to run one multiply; only honoured in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when results are final.
- pe_clr  output  1  one-cycle accumulator clear to all PEs; drives the PE reset input.
- mem_rd_en  output  1  operand buffer read strobe.
- mem_k  output  KW  index of the A column / B row being read.
- a_col  input  N*DW  A[i][k] in lane i; valid exactly 1 cycle after mem_rd_en.
- b_row  input  N*DW  B[k][j] in lane j; valid exactly 1 cycle after mem_rd_en.
- pe_a  output  N*DW  skewed left-edge operands, lane i to PE row i.
- pe_b  output  N*DW  skewed top-edge operands, lane j to PE column j.

Behaviour:
- Reset values (on reset): state IDLE; busy=0, done=0, pe_clr=0, mem_rd_en=0, mem_k=0; all skew registers and pe_a/pe_b cleared to 0.
- Reset wins over every other input in the same cycle, including mid-run.
- State machine: IDLE -> CLEAR -> FEED -> SKEW -> DRAIN -> DONE -> IDLE.
  - IDLE: start=1 moves to CLEAR.
  - CLEAR: 1 cycle with pe_clr=1.
  - FEED: N cycles. mem_rd_en=1 and mem_k counts 0..N-1, one step per cycle.
  - SKEW: N cycles (1-cycle read latency plus N-1 skew), so the last lane fully empties.
  - DRAIN: DRAIN_CYC cycles, with a down-counter loaded on entry.
  - DONE: 1 cycle with done=1, then IDLE.
- Start handling: start outside IDLE is ignored (not queued). Start in the DONE cycle is also ignored.
- Skew path, lane i:
  - Data captured from a_col/b_row (1 cycle after the read) enters a delay line of depth i.
  - A valid bit travels alongside the data; invalid slots output 0 (+0.0).
  - pe_a lane i, pe_b lane j are registered outputs.
- Timing, with start sampled at cycle 0:
  - CLEAR at cycle 1; read of k at cycle 2+k.
  - A[i][k] appears on pe_a lane i at cycle 3+k+i; B[k][j] appears on pe_b lane j at cycle 3+k+j.
  - SKEW occupies cycles N+2..2N+1; DRAIN occupies 2N+2..2N+1+DRAIN_CYC.
  - done at cycle 2N+2+DRAIN_CYC; busy falls in the same cycle that done is seen (busy=0 from the next cycle).
- Outside the valid windows, pe_a and pe_b are all zero, including during CLEAR, so the accumulators are not disturbed.
- Operand data is never modified: no arithmetic in this block, only selection and zeroing.
- Back-to-back runs: the earliest next start is the cycle after DONE. It must reproduce identical timing.

Decomposition:
- Package systolic_pkg holds:
  - state encoding (IDLE, CLEAR, FEED, SKEW, DRAIN, DONE);
  - DW default;
  - ZERO_OPERAND constant (32'h0).
- Sub-module skew_delay_line (params DEPTH, DW):
  - data+valid shift register; output zero when invalid;
  - DEPTH=0 is a wire-through;
  - instantiated once per lane for both A and B.

Test Plan:
- Reset mid-run: assert reset at cycle 5 of a run. Next cycle: busy=0, pe_a/pe_b=0, mem_rd_en=0. A fresh start then gives done at cycle 18 after that start.
- Nominal run (N=4, DRAIN_CYC=8, a_col lane i = 32'h3F800000 + (i<<4) + k):
  - pe_clr at cycle 1 only; mem_k=0,1,2,3 at cycles 2..5;
  - pe_a lane 2 = A[2][0] at cycle 5, A[2][3] at cycle 8, 0 at cycle 9;
  - done at cycle 18 only.
- Zero skew slots: during cycles 3..10, check pe_a lane 3 = 0 at cycles 3..5 and 10+. pe_b lanes mirror pe_a timing.
- Ignored start: pulse start at cycles 4 and 18 (DONE). No second run; busy=0 from cycle 19, mem_rd_en stays 0.
- Back-to-back: start at 0 and 19. The second run shows pe_clr at 20 and done at 37.
- End-to-end: with the PE array attached, A = all 32'h40000000 (2.0) and B = all 32'h3F800000 (1.0). Every out_z = 32'h41000000 (8.0) at done.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feed controller.
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_SKEW,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int          DW_DEF       = 32;
  localparam logic [31:0] ZERO_OPERAND = 32'h0;

endpackage

// File: rtl/skew_delay_line.sv
// Data+valid shift register of DEPTH stages; emits zero for invalid slots.
module skew_delay_line
  import systolic_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_vld,
  output logic [DW-1:0] out_data
);

  localparam logic [DW-1:0] ZERO = DW'(ZERO_OPERAND);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, reset};
    assign out_data = in_vld ? in_data : ZERO;
  end else begin : g_line
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    // Gate at the input so every stage already holds +0.0 in idle slots.
    always_comb begin
      data_d[0] = in_vld ? in_data : ZERO;
      vld_d     = '0;
      vld_d[0]  = in_vld;
      for (int s = 1; s < DEPTH; s++) begin
        data_d[s] = data_q[s-1];
        vld_d[s]  = vld_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < DEPTH; s++) data_q[s] <= ZERO;
        vld_q <= '0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end

    assign out_data = vld_q[DEPTH-1] ? data_q[DEPTH-1] : ZERO;
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequences one N x N multiply: clear PEs, stream skewed A columns / B rows, drain, done.
//   state   | meaning
//   IDLE    | waiting for start
//   CLEAR   | one-cycle accumulator clear
//   FEED    | read A column k / B row k, k = 0..N-1
//   SKEW    | read latency plus skew tail leaves the delay lines
//   DRAIN   | DRAIN_CYC cycles for the array to settle
//   DONE    | one-cycle done pulse
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int N         = 4,
  parameter int DW        = DW_DEF,
  parameter int DRAIN_CYC = 8,
  parameter int KW        = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pe_clr,
  output logic          mem_rd_en,
  output logic [KW-1:0] mem_k,
  input  logic [N*DW-1:0] a_col,
  input  logic [N*DW-1:0] b_row,
  output logic [N*DW-1:0] pe_a,
  output logic [N*DW-1:0] pe_b
);

  localparam int CNT_MAX = (N > DRAIN_CYC) ? N : DRAIN_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic          rd_vld_q, rd_vld_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    pe_clr    = 1'b0;
    mem_rd_en = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        pe_clr  = 1'b1;
        k_d     = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        mem_rd_en = 1'b1;
        if (k_q == KW'(N - 1)) begin
          k_d     = '0;
          cnt_d   = CW'(N - 1);
          state_d = S_SKEW;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_SKEW: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(DRAIN_CYC - 1);
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rd_vld_d = mem_rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign mem_k = k_q;

  // Buffer data lands one cycle after the strobe; rd_vld_q marks it.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(.DEPTH(i), .DW(DW)) u_skew_a (
      .clk      (clk),
      .reset    (reset),
      .in_data  (a_col[i*DW +: DW]),
      .in_vld   (rd_vld_q),
      .out_data (pe_a[i*DW +: DW])
    );
    skew_delay_line #(.DEPTH(i), .DW(DW)) u_skew_b (
      .clk      (clk),
      .reset    (reset),
      .in_data  (b_row[i*DW +: DW]),
      .in_vld   (rd_vld_q),
      .out_data (pe_b[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: operand buffer model, per-cycle scoreboard, PE array model.
module tb_systolic_feed_ctrl;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int DC = 8;
  localparam int KW = 2;
  localparam int T  = 2*N + 2 + DC;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            busy, done, pe_clr, mem_rd_en;
  logic [KW-1:0]   mem_k;
  logic [N*DW-1:0] a_col, b_row, pe_a, pe_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] a_base, b_base, step;

  typedef struct {
    logic            busy;
    logic            done;
    logic            clr;
    logic            rd;
    logic [KW-1:0]   k;
    logic [N*DW-1:0] pa;
    logic [N*DW-1:0] pb;
  } exp_t;

  exp_t sb[$];
  logic [N*DW-1:0] hist_a [T+1];
  logic [N*DW-1:0] hist_b [T+1];

  systolic_feed_ctrl #(.N(N), .DW(DW), .DRAIN_CYC(DC), .KW(KW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pe_clr    (pe_clr),
    .mem_rd_en (mem_rd_en),
    .mem_k     (mem_k),
    .a_col     (a_col),
    .b_row     (b_row),
    .pe_a      (pe_a),
    .pe_b      (pe_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] a_val(input int i, input int k);
    return a_base + step * 32'((i << 4) + k);
  endfunction

  function automatic logic [31:0] b_val(input int j, input int k);
    return b_base + step * 32'((j << 4) + k);
  endfunction

  // Registered operand buffer; junk on idle cycles so zeroing is exercised.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mem_rd_en) begin
        a_col[i*DW +: DW] <= a_val(i, int'(mem_k));
        b_row[i*DW +: DW] <= b_val(i, int'(mem_k));
      end else begin
        a_col[i*DW +: DW] <= 32'hDEAD_BE00 + 32'(i);
        b_row[i*DW +: DW] <= 32'hCAFE_F000 + 32'(i);
      end
    end
  end

  function automatic logic [63:0] sp2dp(input logic [31:0] f);
    if (f[30:0] == 31'h0) return {f[31], 63'h0};
    return {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'h0};
  endfunction

  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    if (d[62:0] == 63'h0) return {d[63], 31'h0};
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  task automatic push_run();
    exp_t e;
    for (int c = 0; c <= T; c++) begin
      e.busy = (c >= 1);
      e.done = (c == T);
      e.clr  = (c == 1);
      e.rd   = (c >= 2) && (c <= N + 1);
      e.k    = e.rd ? KW'(c - 2) : '0;
      e.pa   = '0;
      e.pb   = '0;
      for (int i = 0; i < N; i++) begin
        if ((c - 3 - i >= 0) && (c - 3 - i < N)) begin
          e.pa[i*DW +: DW] = a_val(i, c - 3 - i);
          e.pb[i*DW +: DW] = b_val(i, c - 3 - i);
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic run_one(input string tag, input bit ign);
    exp_t e;
    push_run();
    for (int c = 0; c <= T; c++) begin
      @(negedge clk);
      start = (c == 0) || (ign && (c == 4 || c == T));
      e = sb.pop_front();
      hist_a[c] = pe_a;
      hist_b[c] = pe_b;
      checks += 6;
      if (busy !== e.busy) begin failures++;
        $display("FAIL %s busy c=%0d got=%b exp=%b", tag, c, busy, e.busy); end
      if (done !== e.done) begin failures++;
        $display("FAIL %s done c=%0d got=%b exp=%b", tag, c, done, e.done); end
      if (pe_clr !== e.clr) begin failures++;
        $display("FAIL %s pe_clr c=%0d got=%b exp=%b", tag, c, pe_clr, e.clr); end
      if (mem_rd_en !== e.rd) begin failures++;
        $display("FAIL %s mem_rd_en c=%0d got=%b exp=%b", tag, c, mem_rd_en, e.rd); end
      if (pe_a !== e.pa) begin failures++;
        $display("FAIL %s pe_a c=%0d got=%h exp=%h", tag, c, pe_a, e.pa); end
      if (pe_b !== e.pb) begin failures++;
        $display("FAIL %s pe_b c=%0d got=%h exp=%h", tag, c, pe_b, e.pb); end
      if (e.rd) begin
        checks++;
        if (mem_k !== e.k) begin failures++;
          $display("FAIL %s mem_k c=%0d got=%0d exp=%0d", tag, c, mem_k, e.k); end
      end
    end
    if (ign) begin
      for (int c = T + 1; c <= T + 6; c++) begin
        @(negedge clk);
        start = 1'b0;
        checks += 3;
        if (busy !== 1'b0) begin failures++;
          $display("FAIL %s idle_busy c=%0d got=%b exp=0", tag, c, busy); end
        if (mem_rd_en !== 1'b0) begin failures++;
          $display("FAIL %s idle_rd c=%0d got=%b exp=0", tag, c, mem_rd_en); end
        if (pe_clr !== 1'b0) begin failures++;
          $display("FAIL %s idle_clr c=%0d got=%b exp=0", tag, c, pe_clr); end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (busy !== 1'b0)      begin failures++; $display("FAIL rst busy got=%b exp=0", busy); end
    if (done !== 1'b0)      begin failures++; $display("FAIL rst done got=%b exp=0", done); end
    if (pe_clr !== 1'b0)    begin failures++; $display("FAIL rst pe_clr got=%b exp=0", pe_clr); end
    if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL rst mem_rd_en got=%b exp=0", mem_rd_en); end
    if (mem_k !== '0)       begin failures++; $display("FAIL rst mem_k got=%0d exp=0", mem_k); end
    if (pe_a !== '0)        begin failures++; $display("FAIL rst pe_a got=%h exp=0", pe_a); end
    if (pe_b !== '0)        begin failures++; $display("FAIL rst pe_b got=%h exp=0", pe_b); end
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    a_base = 32'h3F80_0000; b_base = 32'h4040_0000; step = 32'd1;
    run_one("nominal", 1'b0);
  endtask

  task automatic test_ignored_start();
    a_base = 32'h3F80_0000; b_base = 32'h4040_0000; step = 32'd1;
    run_one("ignored_start", 1'b1);
  endtask

  task automatic test_back_to_back();
    a_base = 32'h4100_0000; b_base = 32'h4120_0000; step = 32'd1;
    run_one("b2b_first", 1'b0);
    run_one("b2b_second", 1'b0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    checks += 4;
    if (busy !== 1'b0)      begin failures++; $display("FAIL midrst busy got=%b exp=0", busy); end
    if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL midrst mem_rd_en got=%b exp=0", mem_rd_en); end
    if (pe_a !== '0)        begin failures++; $display("FAIL midrst pe_a got=%h exp=0", pe_a); end
    if (pe_b !== '0)        begin failures++; $display("FAIL midrst pe_b got=%h exp=0", pe_b); end
    run_one("after_reset", 1'b0);
  endtask

  // A PE(i,j) sees pe_a lane i after j hops and pe_b lane j after i hops.
  task automatic test_end_to_end();
    real         acc;
    logic [31:0] av, bv, z;
    a_base = 32'h4000_0000; b_base = 32'h3F80_0000; step = 32'd0;
    run_one("e2e", 1'b0);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0.0;
        for (int t = 0; t <= T; t++) begin
          if (t - j >= 0 && t - i >= 0) begin
            av = hist_a[t-j][i*DW +: DW];
            bv = hist_b[t-i][j*DW +: DW];
            if (av != 32'h0 && bv != 32'h0)
              acc = acc + $bitstoreal(sp2dp(av)) * $bitstoreal(sp2dp(bv));
          end
        end
        z = dp2sp($realtobits(acc));
        checks++;
        if (z !== 32'h4100_0000) begin failures++;
          $display("FAIL e2e out_z[%0d][%0d] got=%h exp=41000000", i, j, z); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a_base = '0; b_base = '0; step = '0;
    test_reset();
    test_nominal();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    test_end_to_end();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
